alu_exec_ctrl: RTL and testbench
================================

// Module: alu_exec_ctrl
// PURPOSE
//  Parametrised ALU control-plus-execute stage for the datapath. Decodes alu_op/alu_function
//  into a 4-bit alu_control code, executes the operation on src_a/src_b, and returns a
//  registered result over a valid/ready handshake. Single-cycle ops take one cycle; MUL is iterative.
//  Sits between decode and writeback.
// PARAMETERS
//  WIDTH     32  operand/result width in bits (>=8)
//  MUL_STEP  1   multiplier bits retired per cycle; must divide WIDTH; MUL latency = WIDTH/MUL_STEP
// PORTS
//  clk           in   1      rising-edge clock
//  reset         in   1      synchronous, active-high reset
//  in_valid      in   1      operation request valid
//  in_ready      out  1      stage can accept a request this cycle
//  alu_op        in   2      00/01 ADD, 10 use alu_function, 11 PASS_B
//  alu_function  in   6      R-type function field
//  src_a, src_b  in   WIDTH  operands
//  out_valid     out  1      result registers valid
//  out_ready     in   1      consumer accepts result
//  result        out  WIDTH  operation result
//  zero          out  1      result == 0
//  illegal       out  1      unknown function code (sampled with result)
//  alu_control   out  4      registered decoded control code of the held result
// BEHAVIOUR
//  Decode (alu_op=10): 000000 OR/0000, 000001 AND/0001, 000010 ADD/0010, 000100 XOR/0100,
//   000110 SUB/0110, 000111 SLT signed/0111, 001000 SLTU unsigned/1000, 001001 MUL/1001.
//   alu_op=11 -> 1111 PASS_B (result=src_b); alu_op=00/01 -> 0010 ADD.
//  Unknown function: alu_control=1110, result=0, illegal=1, single-cycle. Decode fully
//   combinational, no inferred latches.
//  ADD/SUB/MUL wrap modulo 2^WIDTH; MUL returns low WIDTH bits; SLT/SLTU return 0 or 1 zero-extended.
//  Accept = in_valid & in_ready. in_ready = (state==IDLE) & (!out_valid | out_ready).
//  FSM: IDLE --accept non-MUL--> IDLE, out_valid=1 after that edge (latency 1).
//       IDLE --accept MUL--> MUL; operands latched, cnt=WIDTH/MUL_STEP-1.
//       MUL: each cycle add/shift MUL_STEP bits; cnt==0 -> IDLE, out_valid=1 (latency WIDTH/MUL_STEP).
//  Output regs hold stable while out_valid & !out_ready; cleared (out_valid=0) on out_ready
//   with no new accept. Accept and out_ready in same cycle: old result retires, new loads.
//  in_valid during MUL is ignored (in_ready=0); inputs need not be held after accept.
//  Reset: out_valid=0, result=0, zero=0, illegal=0, alu_control=0000, state=IDLE, cnt=0;
//   reset mid-MUL aborts the op with no output.
// CONFIGURATION
//  ALU_MUL_EN defined: MUL (001001) implemented as above.
//  ALU_MUL_EN undefined: no multiplier or MUL state; 001001 treated as unknown
//   (alu_control=1110, result=0, illegal=1, latency 1); in_ready = !out_valid | out_ready.
// TESTING
//  ADD: op=10 fn=000010 a=7 b=5, out_ready=1 -> next cycle out_valid=1 result=12 ctrl=0010 zero=0.
//  SUB wrap/zero: fn=000110 a=3 b=3 -> result=0 zero=1; a=0 b=1 -> result=0xFFFFFFFF.
//  SLT vs SLTU: a=0xFFFFFFFF b=1 -> SLT result=1, SLTU result=0; illegal fn=111111 -> illegal=1 result=0.
//  Backpressure: out_ready=0 two results -> first held stable, in_ready=0, second accepted the
//   cycle out_ready rises; op=11 b=0xA5 -> result=0xA5 ctrl=1111.
//  MUL (ALU_MUL_EN, WIDTH=32, MUL_STEP=1): a=0x10001 b=0x10001 -> out_valid 32 cycles after
//   accept, result=0x00020001; in_ready=0 throughout; MUL_STEP=4 -> latency 8.
//  Reset mid-MUL at cycle 10 -> out_valid stays 0, in_ready=1 cycle after reset deasserts.

Source files
------------

// File: rtl/alu_exec_ctrl.sv
// -----------------------------------------------------------------------------
// alu_exec_ctrl
//  ALU control-plus-execute stage sitting between decode and writeback.
//  Decodes alu_op/alu_function into a 4-bit alu_control code, executes the
//  operation on src_a/src_b and returns a registered result over a
//  valid/ready handshake. Single-cycle operations have latency 1; MUL is an
//  iterative shift-and-add retiring MUL_STEP multiplier bits per cycle
//  (latency WIDTH/MUL_STEP).
//
//  Configuration macro: ALU_MUL_EN
//    defined   - MUL (function 001001, alu_control 1001) is implemented.
//    undefined - no multiplier datapath or MUL state; 001001 decodes as an
//                unknown function (alu_control 1110, result 0, illegal 1).
//
//  Ports
//    clk          in   rising-edge clock
//    reset        in   synchronous, active-high reset
//    in_valid     in   operation request valid
//    in_ready     out  stage can accept a request this cycle
//    alu_op       in   00/01 ADD, 10 use alu_function, 11 PASS_B
//    alu_function in   R-type function field
//    src_a/src_b  in   operands
//    out_valid    out  result registers valid
//    out_ready    in   consumer accepts result
//    result       out  operation result
//    zero         out  result == 0
//    illegal      out  unknown function code (held with result)
//    alu_control  out  decoded control code of the held result
// -----------------------------------------------------------------------------
module alu_exec_ctrl #(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       alu_function,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic [3:0]       alu_control
);

  // Reject configurations the iterative multiplier cannot serve.
  if ((WIDTH < 8) || ((WIDTH % MUL_STEP) != 0)) begin : g_bad_cfg
    $error("alu_exec_ctrl: WIDTH must be >= 8 and divisible by MUL_STEP");
  end

  logic [3:0]       ctrl_s;
  logic             illegal_s;
  logic [WIDTH-1:0] exec_s;
  logic             accept_s;

  logic             out_valid_r;
  logic [WIDTH-1:0] result_r;
  logic             zero_r;
  logic             illegal_r;
  logic [3:0]       alu_control_r;

  // Decode alu_op/alu_function into the control code and illegal flag.
  always_comb begin
    ctrl_s    = 4'b1110;
    illegal_s = 1'b0;
    case (alu_op)
      2'b10: begin
        case (alu_function)
          6'b000000: ctrl_s = 4'b0000;
          6'b000001: ctrl_s = 4'b0001;
          6'b000010: ctrl_s = 4'b0010;
          6'b000100: ctrl_s = 4'b0100;
          6'b000110: ctrl_s = 4'b0110;
          6'b000111: ctrl_s = 4'b0111;
          6'b001000: ctrl_s = 4'b1000;
`ifdef ALU_MUL_EN
          6'b001001: ctrl_s = 4'b1001;
`endif
          default: begin
            ctrl_s    = 4'b1110;
            illegal_s = 1'b1;
          end
        endcase
      end
      2'b11:   ctrl_s = 4'b1111;
      default: ctrl_s = 4'b0010;
    endcase
  end

  // Single-cycle execute; MUL and unknown codes yield 0 here (MUL runs in the FSM).
  always_comb begin
    case (ctrl_s)
      4'b0000: exec_s = src_a | src_b;
      4'b0001: exec_s = src_a & src_b;
      4'b0010: exec_s = src_a + src_b;
      4'b0100: exec_s = src_a ^ src_b;
      4'b0110: exec_s = src_a - src_b;
      4'b0111: exec_s = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      4'b1000: exec_s = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
      4'b1111: exec_s = src_b;
      default: exec_s = {WIDTH{1'b0}};
    endcase
  end

`ifdef ALU_MUL_EN
  localparam int MUL_CYC = WIDTH / MUL_STEP;
  localparam int CNT_W   = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] acc_next_s;
  logic             is_mul_s;

  assign is_mul_s = (ctrl_s == 4'b1001);
  assign in_ready = (state_r == ST_IDLE) & (~out_valid_r | out_ready);

  // Partial-product accumulation for the MUL_STEP multiplier bits retired this cycle.
  always_comb begin
    acc_next_s = acc_r;
    for (int k = 0; k < MUL_STEP; k++) begin
      if (mplier_r[k]) begin
        acc_next_s = acc_next_s + (mcand_r << k);
      end else begin
        acc_next_s = acc_next_s;
      end
    end
  end
`else
  assign in_ready = ~out_valid_r | out_ready;
`endif

  assign accept_s = in_valid & in_ready;

  // Control FSM and output registers; a held result retires on out_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_r   <= 1'b0;
      result_r      <= {WIDTH{1'b0}};
      zero_r        <= 1'b0;
      illegal_r     <= 1'b0;
      alu_control_r <= 4'b0000;
`ifdef ALU_MUL_EN
      state_r       <= ST_IDLE;
      cnt_r         <= {CNT_W{1'b0}};
      mcand_r       <= {WIDTH{1'b0}};
      mplier_r      <= {WIDTH{1'b0}};
      acc_r         <= {WIDTH{1'b0}};
`endif
    end else begin
`ifdef ALU_MUL_EN
      if (state_r == ST_MUL) begin
        acc_r    <= acc_next_s;
        mcand_r  <= mcand_r << MUL_STEP;
        mplier_r <= mplier_r >> MUL_STEP;
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_r       <= ST_IDLE;
          out_valid_r   <= 1'b1;
          result_r      <= acc_next_s;
          zero_r        <= (acc_next_s == {WIDTH{1'b0}});
          illegal_r     <= 1'b0;
          alu_control_r <= 4'b1001;
        end else begin
          cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end else if (accept_s && is_mul_s) begin
        // Any held result retires on this edge (in_ready implies out_ready or empty).
        state_r     <= ST_MUL;
        cnt_r       <= CNT_W'(MUL_CYC - 1);
        mcand_r     <= src_a;
        mplier_r    <= src_b;
        acc_r       <= {WIDTH{1'b0}};
        out_valid_r <= 1'b0;
      end else
`endif
      if (accept_s) begin
        out_valid_r   <= 1'b1;
        result_r      <= exec_s;
        zero_r        <= (exec_s == {WIDTH{1'b0}});
        illegal_r     <= illegal_s;
        alu_control_r <= ctrl_s;
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  assign out_valid   = out_valid_r;
  assign result      = result_r;
  assign zero        = zero_r;
  assign illegal     = illegal_r;
  assign alu_control = alu_control_r;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_ctrl
//  Table-driven vectors pushed through a scoreboard, plus hand-written
//  sequences for latency, backpressure, MUL timing and reset.
// -----------------------------------------------------------------------------
module tb_alu_exec_ctrl;
  localparam int W     = 32;
  localparam int MSTEP = 1;
  localparam int MLAT  = W / MSTEP;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   alu_op;
  logic [5:0]   alu_function;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         illegal;
  logic [3:0]   alu_control;

  alu_exec_ctrl #(.WIDTH(W), .MUL_STEP(MSTEP)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .alu_function(alu_function), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero),
    .illegal(illegal), .alu_control(alu_control)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [5:0]   fn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [3:0]   ctrl;
    logic         ill;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   ctrl;
    logic         ill;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  exp_t mon_e;
  int   pass_cnt = 0;
  int   chk_cnt  = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Drive one request, waiting (bounded) for in_ready; expectation queued when accepted.
  task automatic issue(input vec_t v);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1; alu_op = v.op; alu_function = v.fn; src_a = v.a; src_b = v.b;
    #1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      chk_cnt++;
      $display("FAIL issue_timeout: in_ready stayed 0, expected 1 within 100 cycles");
    end else begin
      sb.push_back(exp_t'{v.res, v.ctrl, v.ill});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    alu_op = 2'($urandom); alu_function = 6'($urandom);
    src_a = $urandom; src_b = $urandom;
  endtask

  // Scoreboard monitor: compare every result the consumer takes.
  always @(negedge clk) begin
    #3;
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk_cnt++;
        $display("FAIL sb_unexpected: got result 0x%0h, expected no output", result);
      end else begin
        mon_e = sb.pop_front();
        check("result", result, mon_e.res);
        check("zero", W'(zero), W'(mon_e.res == '0));
        check("illegal", W'(illegal), W'(mon_e.ill));
        check("alu_control", W'(alu_control), W'(mon_e.ctrl));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int bad_ready;
    int seen;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = 2'b00; alu_function = 6'b000000; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #2;
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_result", result, W'(0));
    check("rst_zero", W'(zero), W'(0));
    check("rst_illegal", W'(illegal), W'(0));
    check("rst_ctrl", W'(alu_control), W'(0));
    check("rst_in_ready", W'(in_ready), W'(1));

    // op, fn, a, b, result, ctrl, illegal
    vecs.push_back(vec_t'{2'b10, 6'b000010, 32'd7, 32'd5, 32'd12, 4'b0010, 1'b0});
    vecs.push_back(vec_t'{2'b10, 6'b000110, 32'd3, 32'd3, 32'd0, 4'b0110, 1'b0});
    vecs.push_back(vec_t'{2'b10, 6'b000110, 32'd0, 32'd1, 32'hFFFF_FFFF, 4'b0110, 1'b0});
    vecs.push_back(vec_t'{2'b10, 6'b000111, 32'hFFFF_FFFF, 32'd1, 32'd1, 4'b0111, 1'b0});
    vecs.push_back(vec_t'{2'b10, 6'b001000, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b1000, 1'b0});
    vecs.push_back(vec_t'{2'b10, 6'b000111, 32'd1, 32'hFFFF_FFFF, 32'd0, 4'b0111, 1'b0});
    vecs.push_back(vec_t'{2'b10, 6'b001000, 32'd1, 32'hFFFF_FFFF, 32'd1, 4'b1000, 1'b0});
    vecs.push_back(vec_t'{2'b10, 6'b111111, 32'd5, 32'd6, 32'd0, 4'b1110, 1'b1});
    vecs.push_back(vec_t'{2'b10, 6'b000000, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 4'b0000, 1'b0});
    vecs.push_back(vec_t'{2'b10, 6'b000001, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 4'b0001, 1'b0});
    vecs.push_back(vec_t'{2'b10, 6'b000100, 32'h0000_FF00, 32'h0000_0FF0, 32'h0000_F0F0, 4'b0100, 1'b0});
    vecs.push_back(vec_t'{2'b00, 6'b000110, 32'hFFFF_FFFF, 32'd2, 32'd1, 4'b0010, 1'b0});
    vecs.push_back(vec_t'{2'b01, 6'b111111, 32'd10, 32'd20, 32'd30, 4'b0010, 1'b0});
    vecs.push_back(vec_t'{2'b11, 6'b000110, 32'h1234_5678, 32'h0000_00A5, 32'h0000_00A5, 4'b1111, 1'b0});
    vecs.push_back(vec_t'{2'b10, 6'b000010, 32'h8000_0000, 32'h8000_0000, 32'd0, 4'b0010, 1'b0});
`ifndef ALU_MUL_EN
    vecs.push_back(vec_t'{2'b10, 6'b001001, 32'd3, 32'd4, 32'd0, 4'b1110, 1'b1});
`endif
    foreach (vecs[i]) issue(vecs[i]);
    repeat (3) @(negedge clk);

    // ADD latency: result valid on the edge after accept.
    issue(vec_t'{2'b10, 6'b000010, 32'd100, 32'd23, 32'd123, 4'b0010, 1'b0});
    @(negedge clk);
    #2;
    check("add_latency_valid", W'(out_valid), W'(1));
    repeat (2) @(negedge clk);

    // Backpressure: first result held, second accepted when out_ready rises.
    @(negedge clk);
    out_ready = 1'b0;
    issue(vec_t'{2'b10, 6'b000010, 32'd1, 32'd2, 32'd3, 4'b0010, 1'b0});
    fork
      issue(vec_t'{2'b11, 6'b000000, 32'd9, 32'h0000_00A5, 32'h0000_00A5, 4'b1111, 1'b0});
      begin
        repeat (3) begin
          @(negedge clk);
          #2;
          check("bp_hold_valid", W'(out_valid), W'(1));
          check("bp_hold_result", result, W'(3));
          check("bp_in_ready", W'(in_ready), W'(0));
        end
        @(negedge clk);
        out_ready = 1'b1;
        #2;
        check("bp_release_ready", W'(in_ready), W'(1));
      end
    join
    repeat (3) @(negedge clk);

`ifdef ALU_MUL_EN
    // MUL latency, in_ready low throughout; stray in_valid must be ignored.
    issue(vec_t'{2'b10, 6'b001001, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 4'b1001, 1'b0});
    in_valid = 1'b1; alu_op = 2'b10; alu_function = 6'b000010;
    n = 0; bad_ready = 0;
    while (!out_valid && n < 200) begin
      if (in_ready) bad_ready++;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    check("mul_latency", W'(n), W'(MLAT));
    check("mul_in_ready_low", W'(bad_ready), W'(0));
    repeat (2) @(negedge clk);
    issue(vec_t'{2'b10, 6'b001001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 4'b1001, 1'b0});
    repeat (MLAT + 3) @(negedge clk);

    // Reset mid-MUL aborts with no output.
    issue(vec_t'{2'b10, 6'b001001, 32'd5, 32'd7, 32'd35, 4'b1001, 1'b0});
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mulrst_in_ready", W'(in_ready), W'(1));
    seen = 0;
    repeat (MLAT + 5) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("mulrst_no_output", W'(seen), W'(0));
`endif

    // Reset clears a held result.
    @(negedge clk);
    out_ready = 1'b0;
    issue(vec_t'{2'b10, 6'b000100, 32'h0000_00FF, 32'h0000_000F, 32'h0000_00F0, 4'b0100, 1'b0});
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rst2_out_valid", W'(out_valid), W'(0));
    check("rst2_result", result, W'(0));
    check("rst2_ctrl", W'(alu_control), W'(0));
    check("rst2_in_ready", W'(in_ready), W'(1));

    repeat (5) @(negedge clk);
    check("sb_empty", W'(sb.size()), W'(0));
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
